// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serialiser. The tx line is registered
// from the FSM state, so it trails the state by one cycle and a queued byte
// reaches the line two cycles after it is written.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count, count_nxt;
  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bitn;
  logic [7:0]    shift;
  logic          push, pop, bit_end;

  assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));
  // A write is accepted only against the registered full flag, so a pop in
  // the same cycle does not rescue a write into a full FIFO.
  assign push = wr_en && !full;
  // IDLE pops immediately; STOP pops on its last cycle so frames abut.
  assign pop  = (count != '0) && ((state == IDLE) || (state == STOP && bit_end));
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
  assign busy = (state != IDLE) || (count != '0);

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // FIFO pointers, occupancy, full flag and the dropped-write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == (PW+1)'(FIFO_DEPTH));
      overflow <= wr_en && full;
    end
  end

  // Frame FSM with baud/bit counters; tx is registered from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud  <= '0;
      bitn  <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      unique case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shift <= mem[rptr];
            bitn  <= '0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shift <= shift >> 1;
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rptr];
              bitn  <= '0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end
endmodule
